ntt_stream_engine: RTL and testbench
====================================

NTT_STREAM_ENGINE -- requirements
Module: ntt_stream_engine

Interface
REQ-001 Parameter N, default 64: transform length and lane count; SHALL be a power of two, N >= 2.
REQ-002 Parameter DW, default 64: data/twiddle width in bits.
REQ-003 Parameter Q, default 64'hFFFF_FFFF_0000_0001: prime modulus; SHALL satisfy Q < 2^DW.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin transform; honoured only in IDLE.
REQ-007 inverse  in  1  inverse mode; sampled with accepted start.
REQ-008 n_inv  in  DW  N^-1 mod Q; sampled with accepted start.
REQ-009 col_valid  in  1  column k offered on x_in/w_col.
REQ-010 col_ready  out  1  engine accepts a column.
REQ-011 x_in  in  DW  input element x[k], < Q.
REQ-012 w_col  in  N x DW  twiddle column W[0..N-1][k], each < Q.
REQ-013 y_valid  out  1  result vector y valid.
REQ-014 y_ready  in  1  consumer accepts y.
REQ-015 y  out  N x DW  result y[i] = sum_k W[i][k]*x[k] mod Q (times n_inv if inverse).
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, LOAD, DRAIN, SCALE, OUT.
REQ-018 IDLE -> LOAD on start; accumulators cleared, column counter = 0, inverse/n_inv latched; start outside IDLE ignored.
REQ-019 col_ready = 1 only in LOAD; a column transfers on col_valid && col_ready; col_valid low stalls without losing state.
REQ-020 Column counter increments per transfer; after transfer N-1 the FSM enters DRAIN the next cycle.
REQ-021 Each lane is a 2-stage pipeline: stage 1 registers full 2*DW product x_in*w_col[i]; stage 2 does acc <= (acc + (product mod Q)) mod Q.
REQ-022 DRAIN lasts exactly 2 cycles, then SCALE if inverse else OUT.
REQ-023 SCALE lasts 1 cycle: acc[i] <= (acc[i]*n_inv) mod Q; then OUT.
REQ-024 In OUT, y_valid = 1 and y = acc; y stable while y_ready low; OUT -> IDLE on y_valid && y_ready.
REQ-025 Latency, no stalls, forward: y_valid rises N+3 cycles after the start cycle; inverse: N+4.
REQ-026 All accumulators and y always < Q; 2*DW intermediate width, no truncation before reduction.
REQ-027 start asserted in the same cycle as the OUT->IDLE handshake is ignored; new start needed in IDLE.

Reset
REQ-028 rst low asynchronously forces IDLE; col_ready, y_valid, busy = 0; y, accumulators, pipeline registers, counter = 0.
REQ-029 Reset mid-LOAD/DRAIN/SCALE/OUT discards the transform; no partial y_valid after release.
REQ-030 First start accepted on the first rising edge with rst high.

Structure
REQ-031 Package ntt_pkg holds FSM state enum, default N/DW/Q constants, and the mod-Q multiply/add function.
REQ-032 One sub-module ntt_lane (2-stage modular MAC plus scale step), instantiated N times by generate.
REQ-033 Top holds FSM, column counter, latched mode, and handshakes only.

Verification
REQ-034 Identity: N=64, W[i][k]=(i==k), x[k]=k, forward -> y[i]=i, y_valid at cycle 67 after start.
REQ-035 Wrap: N=4, Q=17, all w=16, all x=16 -> each term 1, y[i]=4 for all i.
REQ-036 Inverse: N=4, Q=17, n_inv=13, all w=1, all x=1 -> y[i]=(4*13) mod 17=1, latency N+4=8.
REQ-037 Backpressure: col_valid low 3 cycles after column 1; y_ready low 5 cycles -> same y as unstalled run, y held stable.
REQ-038 Reset mid-LOAD at column 10 -> busy/col_ready/y 0 immediately; subsequent full run yields correct y.
REQ-039 start while busy and start coincident with OUT handshake -> ignored, no second transform.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types, default parameters and modular arithmetic for the streaming NTT engine.
// Operands up to MOD_W bits are reduced through 2*MOD_W-bit intermediates.
package ntt_pkg;

    localparam int unsigned NTT_N_DEF  = 64;
    localparam int unsigned NTT_DW_DEF = 64;
    localparam logic [63:0] NTT_Q_DEF  = 64'hFFFF_FFFF_0000_0001;
    localparam int unsigned MOD_W      = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_SCALE,
        ST_OUT
    } ntt_state_t;

    typedef logic [MOD_W-1:0]   mod_word_t;
    typedef logic [2*MOD_W-1:0] mod_wide_t;

    function automatic mod_word_t mod_red(input mod_wide_t a, input mod_word_t q);
        mod_wide_t r;
        r = a % mod_wide_t'(q);
        return r[MOD_W-1:0];
    endfunction

    // Both addends are already < q, so a single conditional subtract suffices.
    function automatic mod_word_t mod_add(input mod_word_t a, input mod_word_t b, input mod_word_t q);
        logic [MOD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q})
            s = s - {1'b0, q};
        return s[MOD_W-1:0];
    endfunction

    function automatic mod_word_t mod_mul(input mod_word_t a, input mod_word_t b, input mod_word_t q);
        return mod_red(mod_wide_t'(a) * mod_wide_t'(b), q);
    endfunction

endpackage

// File: rtl/ntt_stream_engine_if.sv
// Column-input and result-output handshakes of the streaming NTT engine.
interface ntt_stream_engine_if
    import ntt_pkg::*;
#(
    parameter int unsigned N  = NTT_N_DEF,
    parameter int unsigned DW = NTT_DW_DEF
);
    logic                   col_valid;
    logic                   col_ready;
    logic [DW-1:0]          x_in;
    logic [N-1:0][DW-1:0]   w_col;
    logic                   y_valid;
    logic                   y_ready;
    logic [N-1:0][DW-1:0]   y;

    modport master (
        output col_valid, x_in, w_col, y_ready,
        input  col_ready, y_valid, y
    );

    modport slave (
        input  col_valid, x_in, w_col, y_ready,
        output col_ready, y_valid, y
    );
endinterface

// File: rtl/ntt_lane.sv
// One output lane: registered full-width product, then modular accumulate, plus
// a single-cycle multiply-by-n_inv scale step used by the inverse transform.
module ntt_lane
    import ntt_pkg::*;
#(
    parameter int unsigned   DW = NTT_DW_DEF,
    parameter logic [DW-1:0] Q  = DW'(NTT_Q_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          scale,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] w,
    input  logic [DW-1:0] n_inv,
    output logic [DW-1:0] acc
);

    logic [2*DW-1:0] prod;
    logic            prod_v;
    mod_word_t       acc_next;
    mod_word_t       acc_scaled;

    always_comb begin
        acc_next   = mod_add(mod_word_t'(acc), mod_red(mod_wide_t'(prod), mod_word_t'(Q)), mod_word_t'(Q));
        acc_scaled = mod_mul(mod_word_t'(acc), mod_word_t'(n_inv), mod_word_t'(Q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod   <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            prod_v <= en && !clr;
            if (en)
                prod <= (2*DW)'(x) * (2*DW)'(w);
            // Pipeline is empty by the time SCALE arrives, so the branches never compete.
            if (clr)
                acc <= '0;
            else if (prod_v)
                acc <= DW'(acc_next);
            else if (scale)
                acc <= DW'(acc_scaled);
        end
    end

endmodule

// File: rtl/ntt_stream_engine.sv
// Streaming matrix-vector NTT: one column per accepted beat, N parallel modular MAC lanes,
// optional n_inv scaling for the inverse transform, and a single result handshake.
module ntt_stream_engine
    import ntt_pkg::*;
#(
    parameter int unsigned   N  = NTT_N_DEF,
    parameter int unsigned   DW = NTT_DW_DEF,
    parameter logic [DW-1:0] Q  = DW'(NTT_Q_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                inverse,
    input  logic [DW-1:0]       n_inv,
    output logic                busy,
    ntt_stream_engine_if.slave  s
);

    localparam int unsigned CW = $clog2(N);

    ntt_state_t           state;
    logic [CW-1:0]        col_cnt;
    logic                 drain_cnt;
    logic                 inv_q;
    logic [DW-1:0]        ninv_q;
    logic                 accept;
    logic                 col_xfer;
    logic                 last_col;
    logic [N-1:0][DW-1:0] acc;

    assign accept      = (state == ST_IDLE) && start;
    assign col_xfer    = s.col_valid && s.col_ready;
    assign last_col    = (col_cnt == CW'(N - 1));
    assign s.col_ready = (state == ST_LOAD);
    assign s.y_valid   = (state == ST_OUT);
    assign s.y         = acc;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            col_cnt   <= '0;
            drain_cnt <= 1'b0;
            inv_q     <= 1'b0;
            ninv_q    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_LOAD;
                        col_cnt <= '0;
                        inv_q   <= inverse;
                        ninv_q  <= n_inv;
                    end
                end
                ST_LOAD: begin
                    if (col_xfer) begin
                        col_cnt <= col_cnt + CW'(1);
                        if (last_col) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt)
                        state <= inv_q ? ST_SCALE : ST_OUT;
                end
                ST_SCALE: state <= ST_OUT;
                ST_OUT: begin
                    if (s.y_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        ntt_lane #(
            .DW (DW),
            .Q  (Q)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (accept),
            .en    (col_xfer),
            .scale (state == ST_SCALE),
            .x     (s.x_in),
            .w     (s.w_col[i]),
            .n_inv (ninv_q),
            .acc   (acc[i])
        );
    end

endmodule

// File: tb/tb_ntt_stream_engine.sv
// Bench for ntt_stream_engine: an N=64 default-modulus instance and an N=4, Q=17 instance
// checked against a plain matrix-vector model, with directed latency, stall and reset cases.
`timescale 1ns/1ps
module tb_ntt_stream_engine;
    import ntt_pkg::*;

    localparam int unsigned BN = 64;
    localparam int unsigned SN = 4;
    localparam int unsigned DW = 64;
    localparam logic [63:0] BQ = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] SQ = 64'd17;

    logic        clk = 1'b0;
    logic        rst;
    logic        b_start, b_inv, b_busy;
    logic [63:0] b_ninv;
    logic        s_start, s_inv, s_busy;
    logic [63:0] s_ninv;
    int          cyc = 0;

    ntt_stream_engine_if #(.N(BN), .DW(DW)) b_if ();
    ntt_stream_engine_if #(.N(SN), .DW(DW)) s_if ();

    ntt_stream_engine #(.N(BN), .DW(DW), .Q(BQ)) u_big (
        .clk(clk), .rst(rst), .start(b_start), .inverse(b_inv), .n_inv(b_ninv), .busy(b_busy), .s(b_if)
    );
    ntt_stream_engine #(.N(SN), .DW(DW), .Q(SQ)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .inverse(s_inv), .n_inv(s_ninv), .busy(s_busy), .s(s_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] bw [BN][BN];
    logic [63:0] bx [BN];
    logic [63:0] sw [SN][SN];
    logic [63:0] sx [SN];
    logic [63:0] b_exp [BN];
    logic [63:0] s_exp [SN];
    bit          b_armed, s_armed, b_seen, s_seen, done;
    int          b_t0, s_t0, b_lat, s_lat;
    int          errors, checks;

    task automatic do_check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // y[i] = sum_k W[i][k]*x[k] mod q, optionally times n_inv.
    task automatic model_small(input bit inv, input logic [63:0] ninv);
        logic [127:0] a;
        for (int i = 0; i < SN; i++) begin
            a = '0;
            for (int k = 0; k < SN; k++)
                a = (a + (128'(sw[i][k]) * 128'(sx[k])) % 128'(SQ)) % 128'(SQ);
            if (inv) a = (a * 128'(ninv)) % 128'(SQ);
            s_exp[i] = a[63:0];
        end
    endtask

    task automatic model_big();
        logic [127:0] a;
        for (int i = 0; i < BN; i++) begin
            a = '0;
            for (int k = 0; k < BN; k++)
                a = (a + (128'(bw[i][k]) * 128'(bx[k])) % 128'(BQ)) % 128'(BQ);
            b_exp[i] = a[63:0];
        end
    endtask

    task automatic mon_small();
        int bad;
        if (s_if.y_valid) begin
            checks++;
            if (!s_armed) begin
                errors++;
                $display("FAIL small_unexpected_y_valid: got y_valid=1, required 0 (cycle %0d)", cyc);
            end else begin
                bad = -1;
                for (int i = SN - 1; i >= 0; i--)
                    if (s_if.y[i] !== s_exp[i]) bad = i;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL small_y lane %0d: got %0d, required %0d", bad, s_if.y[bad], s_exp[bad]);
                end
                if (!s_seen) begin
                    s_seen = 1;
                    if (s_lat > 0) do_check("small_latency", 64'(cyc - s_t0), 64'(s_lat));
                end
            end
        end
    endtask

    task automatic mon_big();
        int bad;
        if (b_if.y_valid) begin
            checks++;
            if (!b_armed) begin
                errors++;
                $display("FAIL big_unexpected_y_valid: got y_valid=1, required 0 (cycle %0d)", cyc);
            end else begin
                bad = -1;
                for (int i = BN - 1; i >= 0; i--)
                    if (b_if.y[i] !== b_exp[i]) bad = i;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL big_y lane %0d: got %0d, required %0d", bad, b_if.y[bad], b_exp[bad]);
                end
                if (!b_seen) begin
                    b_seen = 1;
                    if (b_lat > 0) do_check("big_latency", 64'(cyc - b_t0), 64'(b_lat));
                end
            end
        end
    endtask

    // Called at posedge+#1. stall_col>=0 drops col_valid 3 cycles after that column.
    task automatic run_small(input bit inv, input logic [63:0] ninv, input int stall_col,
                             input int ystall, input int lat, input bit hold_start);
        bit ok;
        model_small(inv, ninv);
        s_armed = 1; s_seen = 0; s_lat = lat;
        s_start = 1; s_inv = inv; s_ninv = ninv; s_t0 = cyc;
        @(posedge clk); #1;
        s_start = hold_start; s_inv = 1'b0; s_ninv = '0;
        for (int k = 0; k < SN; k++) begin
            if (stall_col >= 0 && k == stall_col + 1) begin
                s_if.col_valid = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
            end
            s_if.col_valid = 1'b1;
            s_if.x_in = sx[k];
            for (int i = 0; i < SN; i++) s_if.w_col[i] = sw[i][k];
            ok = 0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk); ok = s_if.col_ready;
                @(posedge clk); #1;
            end
            if (!ok) do_check("small_col_accept_timeout", 64'(ok), 64'd1);
        end
        s_if.col_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk); ok = s_if.y_valid;
        end
        if (!ok) begin
            do_check("small_y_valid_timeout", 64'(ok), 64'd1);
            s_armed = 0; s_start = 1'b0;
            return;
        end
        repeat (ystall) @(negedge clk);
        s_if.y_ready = 1'b1;
        @(posedge clk); #1;
        s_if.y_ready = 1'b0; s_armed = 0; s_start = 1'b0;
        do_check("small_busy_after_out", 64'(s_busy), 64'd0);
    endtask

    // Called at posedge+#1. abort_col>=0 pulls reset instead of offering that column.
    task automatic run_big(input int lat, input int abort_col);
        bit ok;
        model_big();
        b_armed = 1; b_seen = 0; b_lat = lat;
        b_start = 1; b_inv = 1'b0; b_ninv = '0; b_t0 = cyc;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int k = 0; k < BN; k++) begin
            if (k == abort_col) begin
                b_armed = 0;
                rst = 1'b0;
                #1;
                do_check("reset_mid_load_busy", 64'(b_busy), 64'd0);
                do_check("reset_mid_load_col_ready", 64'(b_if.col_ready), 64'd0);
                do_check("reset_mid_load_y_nonzero", 64'(b_if.y != '0), 64'd0);
                b_if.col_valid = 1'b0;
                return;
            end
            b_if.col_valid = 1'b1;
            b_if.x_in = bx[k];
            for (int i = 0; i < BN; i++) b_if.w_col[i] = bw[i][k];
            ok = 0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk); ok = b_if.col_ready;
                @(posedge clk); #1;
            end
            if (!ok) do_check("big_col_accept_timeout", 64'(ok), 64'd1);
        end
        b_if.col_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk); ok = b_if.y_valid;
        end
        if (!ok) begin
            do_check("big_y_valid_timeout", 64'(ok), 64'd1);
            b_armed = 0;
            return;
        end
        b_if.y_ready = 1'b1;
        @(posedge clk); #1;
        b_if.y_ready = 1'b0; b_armed = 0;
        do_check("big_busy_after_out", 64'(b_busy), 64'd0);
    endtask

    initial begin
        int bad;
        logic [63:0] r;
        errors = 0; checks = 0; done = 0;
        b_armed = 0; s_armed = 0; b_seen = 0; s_seen = 0;
        b_t0 = 0; s_t0 = 0; b_lat = 0; s_lat = 0;
        rst = 1'b1;
        b_start = 1'b0; b_inv = 1'b0; b_ninv = '0;
        s_start = 1'b0; s_inv = 1'b0; s_ninv = '0;
        b_if.col_valid = 1'b0; b_if.y_ready = 1'b0; b_if.x_in = '0; b_if.w_col = '0;
        s_if.col_valid = 1'b0; s_if.y_ready = 1'b0; s_if.x_in = '0; s_if.w_col = '0;
        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    mon_small();
                    mon_big();
                end
            end
            begin
                #2 rst = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                do_check("reset_big_busy", 64'(b_busy), 64'd0);
                do_check("reset_big_col_ready", 64'(b_if.col_ready), 64'd0);
                do_check("reset_big_y_valid", 64'(b_if.y_valid), 64'd0);
                do_check("reset_big_y_nonzero", 64'(b_if.y != '0), 64'd0);
                do_check("reset_small_busy", 64'(s_busy), 64'd0);
                do_check("reset_small_col_ready", 64'(s_if.col_ready), 64'd0);
                do_check("reset_small_y_nonzero", 64'(s_if.y != '0), 64'd0);

                // Identity, started on the first edge with reset released.
                for (int i = 0; i < BN; i++) begin
                    bx[i] = 64'(i);
                    for (int k = 0; k < BN; k++) bw[i][k] = (i == k) ? 64'd1 : 64'd0;
                end
                model_big();
                bad = 0;
                for (int i = 0; i < BN; i++) if (b_exp[i] != 64'(i)) bad++;
                do_check("model_identity_pin_bad_lanes", 64'(bad), 64'd0);
                rst = 1'b1;
                run_big(BN + 3, -1);

                // Wrap: 16*16 = 256 = 1 mod 17, four terms -> 4.
                for (int i = 0; i < SN; i++) begin
                    sx[i] = 64'd16;
                    for (int k = 0; k < SN; k++) sw[i][k] = 64'd16;
                end
                model_small(1'b0, '0);
                for (int i = 0; i < SN; i++) do_check("model_wrap_pin", s_exp[i], 64'd4);
                run_small(1'b0, '0, -1, 0, SN + 3, 1'b0);

                // Inverse: 4 * 13 = 52 = 1 mod 17.
                for (int i = 0; i < SN; i++) begin
                    sx[i] = 64'd1;
                    for (int k = 0; k < SN; k++) sw[i][k] = 64'd1;
                end
                model_small(1'b1, 64'd13);
                for (int i = 0; i < SN; i++) do_check("model_inverse_pin", s_exp[i], 64'd1);
                run_small(1'b1, 64'd13, -1, 0, SN + 4, 1'b0);

                // Mixed vector x={3,5,7,11}; rows give {9,10,8,6} mod 17.
                sx[0] = 64'd3; sx[1] = 64'd5; sx[2] = 64'd7; sx[3] = 64'd11;
                for (int k = 0; k < SN; k++) begin
                    sw[0][k] = 64'd1;
                    sw[1][k] = 64'(k + 1);
                    sw[2][k] = 64'd16;
                    sw[3][k] = (k == 3) ? 64'd16 : 64'd0;
                end
                model_small(1'b0, '0);
                do_check("model_mixed_pin0", s_exp[0], 64'd9);
                do_check("model_mixed_pin1", s_exp[1], 64'd10);
                do_check("model_mixed_pin2", s_exp[2], 64'd8);
                do_check("model_mixed_pin3", s_exp[3], 64'd6);
                run_small(1'b0, '0, -1, 0, SN + 3, 1'b0);
                run_small(1'b0, '0, 1, 5, 0, 1'b0);

                // start held through LOAD and the OUT handshake must not launch a second transform.
                run_small(1'b0, '0, -1, 2, 0, 1'b1);
                repeat (SN + 10) @(posedge clk);
                #1;
                do_check("small_no_second_transform", 64'(s_busy), 64'd0);

                // Reset while column 10 is due, then a full run with large operands.
                for (int i = 0; i < BN; i++) begin
                    r = {$urandom(), $urandom()};
                    bx[i] = r % BQ;
                    for (int k = 0; k < BN; k++) begin
                        r = {$urandom(), $urandom()};
                        bw[i][k] = r % BQ;
                    end
                end
                bx[0] = BQ - 64'd1; bw[0][0] = BQ - 64'd1; bw[1][0] = BQ - 64'd1;
                run_big(0, 10);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                repeat (BN + 10) @(posedge clk);
                #1;
                do_check("after_reset_no_partial_busy", 64'(b_busy), 64'd0);
                run_big(BN + 3, -1);
                repeat (3) @(posedge clk);
                done = 1;
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
